// File: rtl/counter_param_pkg.sv
// Shared encodings for the parametrised counter: end-of-range modes and direction.
// Imported by counter_mode_param and counter_prescaler.
package counter_param_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/counter_prescaler.sv
// Enable divider: emits a step on every PRESCALE-th en-high cycle.
// Combinational step output; divider state cleared by RST or clr, held while en=0.
module counter_prescaler
    import counter_param_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic RST,
    input  logic en,
    input  logic clr,
    output logic step
);

    localparam int DW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(PRESCALE - 1);

    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;

    always_comb begin
        div_d = div_q;
        if (clr) begin
            div_d = '0;
        end else if (en) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        end
    end

    assign step = en && (div_q == DIV_LAST);

    always_ff @(posedge clk) begin
        if (RST) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/counter_mode_param.sv
// Modulus counter with wrap/saturate/one-shot end-of-range, registered tc pulse and sticky done.
// Optional enable prescaler compiled in with COUNTER_MODE_PRESCALE_EN.
module counter_mode_param
    import counter_param_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MODULUS  = 256,
    parameter int INIT     = 0,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             en,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             done
);

    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] INIT_VAL = WIDTH'(INIT);

    if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
        $error("counter_mode_param: MODULUS out of range");
    end
    if (INIT < 0 || INIT >= MODULUS) begin : g_bad_init
        $error("counter_mode_param: INIT must be below MODULUS");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("counter_mode_param: PRESCALE must be at least 1");
    end

    logic step;

`ifdef COUNTER_MODE_PRESCALE_EN
    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .RST  (RST),
        .en   (en),
        .clr  (load),
        .step (step)
    );
`else
    assign step = en;
`endif

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] term;
    logic             at_term;
    mode_e            mode_sel;

    assign mode_sel = mode_e'(mode);
    assign term     = (dir == DIR_UP) ? MAX_VAL : '0;
    assign at_term  = (count_q == term);

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        done_d  = done_q;
        if (load) begin
            count_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
            done_d  = 1'b0;
        end else if (step) begin
            // tc reflects any step request at the terminal value, even once done has frozen the count
            tc_d = at_term;
            if (!done_q) begin
                if (at_term) begin
                    case (mode_sel)
                        MODE_SAT:     count_d = count_q;
                        MODE_ONESHOT: done_d  = 1'b1;
                        default:      count_d = (dir == DIR_UP) ? '0 : MAX_VAL;
                    endcase
                end else begin
                    count_d = (dir == DIR_UP) ? count_q + 1'b1 : count_q - 1'b1;
                    if (mode_sel == MODE_ONESHOT && count_d == term) begin
                        done_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            count_q <= INIT_VAL;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            done_q  <= done_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign done  = done_q;

endmodule

// File: tb/tb_counter_mode_param.sv
// Bench for counter_mode_param (WIDTH=4, MODULUS=10): directed plan then random traffic
// checked every cycle against an integer reference model.
module tb_counter_mode_param;

    localparam int WIDTH    = 4;
    localparam int MODULUS  = 10;
    localparam int INIT     = 0;
    localparam int PRESCALE = 4;

    logic             clk = 1'b0;
    logic             RST;
    logic             en;
    logic             dir;
    logic [1:0]       mode;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             done;

    always #5 clk = ~clk;

    counter_mode_param #(
        .WIDTH    (WIDTH),
        .MODULUS  (MODULUS),
        .INIT     (INIT),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk      (clk),
        .RST      (RST),
        .en       (en),
        .dir      (dir),
        .mode     (mode),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .tc       (tc),
        .done     (done)
    );

    int n_chk  = 0;
    int n_pass = 0;

    int m_count = 0;
    int m_tc    = 0;
    int m_done  = 0;
    int m_div   = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference behaviour in plain integer arithmetic.
    task automatic model(input int r, input int e, input int d, input int m, input int l, input int lv);
        int stp;
        int t;
        int delta;
        if (r != 0) begin
            m_count = INIT; m_tc = 0; m_done = 0; m_div = 0;
        end else if (l != 0) begin
            m_count = (lv > MODULUS - 1) ? MODULUS - 1 : lv;
            m_tc = 0; m_done = 0; m_div = 0;
        end else begin
            stp = e;
`ifdef COUNTER_MODE_PRESCALE_EN
            stp = (e != 0 && m_div == PRESCALE - 1) ? 1 : 0;
            if (e != 0) m_div = (m_div + 1) % PRESCALE;
`endif
            m_tc = 0;
            if (stp != 0) begin
                t     = (d != 0) ? MODULUS - 1 : 0;
                delta = (d != 0) ? 1 : -1;
                m_tc  = (m_count == t) ? 1 : 0;
                if (m_done == 0) begin
                    if (m_count != t) begin
                        m_count = m_count + delta;
                        if (m == 2 && m_count == t) m_done = 1;
                    end else if (m == 2) begin
                        m_done = 1;
                    end else if (m != 1) begin
                        m_count = (m_count + delta + MODULUS) % MODULUS;
                    end
                end
            end
        end
    endtask

    task automatic cyc(input int r, input int e, input int d, input int m, input int l, input int lv);
        RST = r[0]; en = e[0]; dir = d[0]; mode = m[1:0]; load = l[0]; load_val = lv[WIDTH-1:0];
        @(posedge clk);
        model(r, e, d, m, l, lv);
        @(negedge clk);
        chk("count", int'(count), m_count);
        chk("tc",    int'(tc),    m_tc);
        chk("done",  int'(done),  m_done);
    endtask

    initial begin
        RST = 1'b1; en = 1'b0; dir = 1'b1; mode = 2'b00; load = 1'b0; load_val = '0;
        @(negedge clk);

        // Reset, with en raised during reset
        cyc(1, 0, 1, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 0);
        chk("rst_count", int'(count), 0);
        chk("rst_tc",    int'(tc),    0);
        chk("rst_done",  int'(done),  0);

        // Wrap up through 9 -> 0
        for (int i = 0; i < 10; i++) begin
            cyc(0, 1, 1, 0, 0, 0);
            chk("wrap_up_tc", int'(tc), (i == 9) ? 1 : 0);
        end
        chk("wrap_up_end", int'(count), 0);

        // Wrap down 0 -> 9
        cyc(0, 0, 1, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, 0);
        chk("wrap_dn_count", int'(count), 9);
        chk("wrap_dn_tc",    int'(tc),    1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("wrap_dn_tc_off", int'(tc), 0);

        // Saturate with clamped load
        cyc(0, 0, 1, 1, 1, 12);
        chk("clamp", int'(count), 9);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 1, 1, 0, 0);
            chk("sat_count", int'(count), 9);
            chk("sat_tc",    int'(tc),    1);
        end

        // One-shot down from 3
        cyc(0, 0, 0, 2, 1, 3);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 2, 0, 0);
            chk("os_count", int'(count), 2 - i);
        end
        chk("os_done", int'(done), 1);
        cyc(0, 1, 0, 2, 0, 0);
        cyc(0, 1, 0, 2, 0, 0);
        chk("os_hold_count", int'(count), 0);
        chk("os_hold_done",  int'(done),  1);
        cyc(0, 0, 0, 2, 1, 5);
        chk("os_reload_count", int'(count), 5);
        chk("os_reload_done",  int'(done),  0);

        // Load beats a simultaneous step
        cyc(0, 1, 1, 0, 1, 4);
        chk("prio_load", int'(count), 4);

        // Mid-count reset overrides load and step
        cyc(1, 1, 1, 0, 1, 7);
        chk("rst_mid", int'(count), INIT);

        // Random traffic
        begin
            int r, e, d, m, l, lv;
            d = 1; m = 0;
            for (int i = 0; i < 2000; i++) begin
                r  = ($urandom_range(99) < 2) ? 1 : 0;
                l  = ($urandom_range(99) < 8) ? 1 : 0;
                e  = ($urandom_range(99) < 75) ? 1 : 0;
                lv = $urandom_range(15);
                if ($urandom_range(99) < 10) d = $urandom_range(1);
                if ($urandom_range(99) < 5)  m = $urandom_range(3);
                cyc(r, e, d, m, l, lv);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
